// File: rtl/vga_plotter_pkg.sv
// vga_plotter_pkg: screen limits, field widths, FIFO entry layout and FSM states shared by the plotter
package vga_plotter_pkg;
    localparam int CW = 15;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam logic [XW-1:0] X_MAX = 8'd160;
    localparam logic [YW-1:0] Y_MAX = 7'd120;
    localparam logic [XW-1:0] X_LAST = X_MAX - 1'b1;
    localparam logic [YW-1:0] Y_LAST = Y_MAX - 1'b1;
    typedef struct packed {
        logic [CW-1:0] colour;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } entry_t;
    localparam int EW = $bits(entry_t);
    typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;
endpackage

// File: rtl/vga_plotter_fifo.sv
// vga_plotter_fifo: DEPTH-entry synchronous FIFO of packed pixel entries
// Ports: clk/rst_n, push_i/data_i enqueue, pop_i dequeue, data_o head entry, count_o occupancy.
// The user never pushes when full nor pops when empty.
module vga_plotter_fifo
    import vga_plotter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [EW-1:0] data_i,
    output logic [EW-1:0] data_o,
    output logic [AW:0]   count_o
);
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= data_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/vga_plotter.sv
// vga_plotter: buffers plot requests and screen fills, issuing one registered pixel write per cycle
// Ports: clk/rst_n; plot_req_i, fill_req_i with vga_color_i/vga_x_i/vga_y_i requests;
// ready_o accept, busy_o work pending, dropped_o sticky reject; out_* pixel write to the VGA adapter.
module vga_plotter
    import vga_plotter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          plot_req_i,
    input  logic          fill_req_i,
    input  logic [CW-1:0] vga_color_i,
    input  logic [XW-1:0] vga_x_i,
    input  logic [YW-1:0] vga_y_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          dropped_o,
    output logic          out_write_o,
    output logic [CW-1:0] out_colour_o,
    output logic [XW-1:0] out_x_o,
    output logic [YW-1:0] out_y_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    state_t        state_q;
    logic [CW-1:0] fill_colour_q;
    logic [XW-1:0] fx_q;
    logic [YW-1:0] fy_q;
    logic          fill_done_q, dropped_q, out_write_q;
    entry_t        out_q;
    logic [AW:0]   count;
    logic [EW-1:0] head;
    logic          push, pop, fill_go, drop, in_range, sweep;
    assign ready_o  = (state_q == IDLE) && (count < FULL);
    assign busy_o   = (count != '0) || (state_q != IDLE);
    assign in_range = (vga_x_i < X_MAX) && (vga_y_i < Y_MAX);
    assign fill_go  = fill_req_i && ready_o;
    // a fill wins over a coincident plot
    assign push     = plot_req_i && ready_o && !fill_req_i && in_range;
    assign drop     = (plot_req_i && !push) || (fill_req_i && !ready_o);
    assign pop      = (count != '0) && (state_q != FILL);
    // fill_done_q marks the extra FILL cycle that lets the last pixel's write finish before ready rises
    assign sweep    = (state_q == FILL) && !fill_done_q;
    vga_plotter_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .data_i ({vga_color_i, vga_x_i, vga_y_i}),
        .data_o (head),
        .count_o(count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fill_colour_q <= '0;
            fx_q          <= '0;
            fy_q          <= '0;
            fill_done_q   <= 1'b0;
            dropped_q     <= 1'b0;
            out_write_q   <= 1'b0;
            out_q         <= '0;
        end else begin
            dropped_q   <= dropped_q || drop;
            out_write_q <= pop || sweep;
            if (pop) out_q <= entry_t'(head);
            else if (sweep) out_q <= '{colour: fill_colour_q, x: fx_q, y: fy_q};
            case (state_q)
                IDLE:
                    if (fill_go) begin
                        fill_colour_q <= vga_color_i;
                        // the head pops this cycle, so only more than one entry needs draining
                        state_q <= (count > ONE) ? DRAIN : FILL;
                    end
                DRAIN:
                    if (count == ONE) state_q <= FILL;
                FILL:
                    if (fill_done_q) begin
                        state_q     <= IDLE;
                        fill_done_q <= 1'b0;
                    end else begin
                        fx_q        <= (fx_q == X_LAST) ? '0 : fx_q + 1'b1;
                        if (fx_q == X_LAST) fy_q <= (fy_q == Y_LAST) ? '0 : fy_q + 1'b1;
                        fill_done_q <= (fx_q == X_LAST) && (fy_q == Y_LAST);
                    end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign dropped_o    = dropped_q;
    assign out_write_o  = out_write_q;
    assign out_colour_o = out_q.colour;
    assign out_x_o      = out_q.x;
    assign out_y_o      = out_q.y;
endmodule

// File: doc/vga_plotter.md
# vga_plotter

Downstream consumer of the datapath's VGA outputs (15-bit 5:5:5 colour, 8-bit x, 7-bit y). Accepts single-pixel plot requests and whole-screen fill requests from the control unit, buffers plots in a small FIFO and issues one registered pixel write per cycle to the VGA adapter. This decouples instruction execution from framebuffer write bandwidth and rejects off-screen coordinates.

## Interface
- DEPTH, 4, plot FIFO entries (power of two, ≥2)
- X_MAX, 160, screen width; valid x is 0..X_MAX-1
- Y_MAX, 120, screen height; valid y is 0..Y_MAX-1
- clock  input  1  single clock, all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- plot_req  input  1  enqueue pixel (vga_color, vga_x, vga_y) this cycle
- fill_req  input  1  fill entire screen with vga_color
- vga_color  input  15  pixel colour from datapath
- vga_x  input  8  pixel x from datapath
- vga_y  input  7  pixel y from datapath
- ready  output  1  request will be accepted this cycle
- busy  output  1  FIFO non-empty or fill in progress
- dropped  output  1  sticky: a request was rejected since reset
- out_write  output  1  VGA adapter write enable, one pixel per high cycle
- out_colour  output  15  pixel colour to adapter
- out_x  output  8  pixel x to adapter
- out_y  output  7  pixel y to adapter

## Operation
- States: IDLE, DRAIN (fill pending, FIFO emptying), FILL.
- ready = (state == IDLE) && (count < DEPTH); derived from registered state only, never from request inputs.
- plot_req && ready && x < X_MAX && y < Y_MAX: push {colour, x, y}.
- plot_req with out-of-range coordinate, or plot_req/fill_req while ready low: request discarded, dropped set.
- fill_req && ready: latch fill colour; go to DRAIN (FIFO non-empty) or FILL (FIFO empty). Fill coordinates are not range-checked.
- plot_req && fill_req same cycle: fill taken, plot discarded, dropped set.
- Every cycle with FIFO non-empty (IDLE or DRAIN): pop head into output registers, out_write = 1; else out_write = 0 (outside FILL).
- DRAIN -> FILL on the cycle the last entry pops.
- FILL: sweep row-major, x fastest, (0,0) through (X_MAX-1, Y_MAX-1), one pixel per cycle, out_write = 1; X_MAX*Y_MAX = 19200 writes. After last pixel -> IDLE; sweep counters return to 0.
- busy = (count != 0) || (state != IDLE).
- dropped clears only on reset.

## Timing
- Reset (asynchronous): state IDLE, FIFO empty, fill counters 0; ready = 1, busy = 0, dropped = 0, out_write = 0, out_colour/out_x/out_y = 0.
- Plot latency: request accepted at edge N into empty FIFO -> out_write high during cycle after edge N+1 (two edges).
- Sustained plots: one accepted per cycle, one written per cycle; FIFO never fills if requests arrive at most every cycle and no fill pending.
- Push and pop in same cycle: count unchanged, head entry written, new entry queued.
- Fill: first fill pixel (0,0) appears the cycle after entering FILL; ready returns high the cycle after the last fill pixel is written.
- Out registers hold last written value while out_write = 0.
- Reset mid-fill or mid-drain: aborts immediately, FIFO contents lost.

## Structure
- Shared package/header vga_defs: X_MAX, Y_MAX, colour width 15, x width 8, y width 7, packed entry layout {colour[29:15], x[14:7], y[6:0]}, state encodings.
- Sub-module plot_fifo: synchronous DEPTH-entry FIFO, 30-bit data, push/pop/count, same clock and asynchronous active-low reset. Top holds FSM, range check, fill counters, output registers.

## Test plan
- Reset with inputs idle -> ready=1, busy=0, dropped=0, out_write=0, outputs 0.
- plot_req (colour 15'h7C00, x=5, y=7) one cycle -> out_write high one cycle two edges later with 7C00/5/7; busy falls after.
- plot_req x=160, y=3 -> no write, dropped=1 and stays 1; subsequent valid plot still written.
- Three back-to-back plots then fill_req colour 15'h001F -> three plot writes in order, then 19200 writes starting (0,0), ending (159,119), ready low throughout, high afterwards.
- plot_req during FILL and plot_req coincident with fill_req -> both discarded, dropped=1, fill unaffected.
- Assert resetn low mid-fill at pixel ~1000 -> out_write 0 immediately, ready=1, busy=0 after release.
